// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks an 8-bit PC through a combinational ROM
// until a halt opcode, with branches, stall hold and PC-wrap fault detection.
// Build option: define FETCH_ILLEGAL_TRAP_EN to fault on the ROM fill opcode.
module fetch_sequencer #(
    parameter logic [7:0] HALT_OP = 8'h88,
    parameter logic [7:0] FILL_OP = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  start_addr_i,
    input  logic        stall_i,
    input  logic [7:0]  inst_i,
    input  logic        branch_taken_i,
    input  logic        branch_dir_i,
    input  logic [7:0]  branch_off_i,
    output logic [7:0]  rom_addr_o,
    output logic [7:0]  inst_o,
    output logic        inst_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] count_o
);

    // state   | meaning
    // IDLE    | waiting for start; PC and count hold the last program's values
    // RUN     | fetching and retiring instructions
    // DONE    | one-cycle completion pulse after a halt
    // FAULT   | sequential PC wrap or trapped fill opcode; waits for start
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [1:0]  state;
    logic [7:0]  pc;
    logic [15:0] count;
    logic        err;

    logic        exec;
    logic        is_halt;
    logic        is_trap;
    logic        wrap_fault;
    logic [7:0]  pc_next;
    logic [15:0] count_inc;

    always_comb begin
        exec       = (state == S_RUN) && !stall_i;
        is_halt    = (inst_i == HALT_OP);
        // Halt wins if the two opcodes are ever configured identical
        is_trap    = TRAP_EN && (inst_i == FILL_OP) && !is_halt;
        wrap_fault = !branch_taken_i && (pc == 8'hFF);
        count_inc  = (count == 16'hFFFF) ? count : count + 16'd1;
        pc_next    = pc + 8'd1;
        if (branch_taken_i) begin
            if (branch_dir_i) begin
                pc_next = pc - branch_off_i;
            end else begin
                pc_next = pc + branch_off_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            pc    <= 8'h00;
            count <= 16'h0000;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FAULT: begin
                    if (start_i) begin
                        pc    <= start_addr_i;
                        count <= 16'h0000;
                        err   <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (exec) begin
                        if (is_halt) begin
                            count <= count_inc;
                            state <= S_DONE;
                        end else if (is_trap) begin
                            err   <= 1'b1;
                            state <= S_FAULT;
                        end else begin
                            count <= count_inc;
                            pc    <= pc_next;
                            if (wrap_fault) begin
                                err   <= 1'b1;
                                state <= S_FAULT;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr_o   = pc;
    assign inst_o       = (state == S_RUN) ? inst_i : 8'h00;
    assign inst_valid_o = exec && !is_trap;
    assign busy_o       = (state == S_RUN);
    assign done_o       = (state == S_DONE);
    assign err_o        = err;
    assign count_o      = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed program scenarios plus
// randomized runs against a cycle-level behavioural model of the fetch rules.
module tb_fetch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  start_addr_i;
    logic        stall_i;
    logic [7:0]  inst_i;
    logic        branch_taken_i;
    logic        branch_dir_i;
    logic [7:0]  branch_off_i;
    logic [7:0]  rom_addr_o;
    logic [7:0]  inst_o;
    logic        inst_valid_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] count_o;

    logic [7:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;
    localparam int M_FAULT = 3;

`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int m_mode;
    int m_pc;
    int m_cnt;
    bit m_err;

    always #5 clk_i = ~clk_i;

    assign inst_i = rom[rom_addr_o];

    fetch_sequencer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .start_addr_i   (start_addr_i),
        .stall_i        (stall_i),
        .inst_i         (inst_i),
        .branch_taken_i (branch_taken_i),
        .branch_dir_i   (branch_dir_i),
        .branch_off_i   (branch_off_i),
        .rom_addr_o     (rom_addr_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .count_o        (count_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    function automatic int sat_inc(input int c);
        return (c < 65535) ? c + 1 : c;
    endfunction

    // Called at posedge+1: checks mid-cycle, advances the model, returns at next posedge+1
    task automatic step();
        int inst;
        bit trap;
        bit valid;
        #4;
        inst  = int'(rom[m_pc[7:0]]);
        trap  = TRAP && (inst == 8'hFF);
        valid = (m_mode == M_RUN) && !stall_i && !trap;
        chk("rom_addr", rom_addr_o, m_pc);
        chk("count", count_o, m_cnt);
        chk("busy", busy_o, m_mode == M_RUN);
        chk("done", done_o, m_mode == M_DONE);
        chk("err", err_o, m_err);
        chk("inst_valid", inst_valid_o, valid);
        if (m_mode == M_RUN) chk("inst", inst_o, inst);
        case (m_mode)
            M_IDLE, M_FAULT: begin
                if (start_i) begin
                    m_pc   = int'(start_addr_i);
                    m_cnt  = 0;
                    m_err  = 1'b0;
                    m_mode = M_RUN;
                end
            end
            M_RUN: begin
                if (!stall_i) begin
                    if (inst == 8'h88) begin
                        m_cnt  = sat_inc(m_cnt);
                        m_mode = M_DONE;
                    end else if (trap) begin
                        m_err  = 1'b1;
                        m_mode = M_FAULT;
                    end else begin
                        m_cnt = sat_inc(m_cnt);
                        if (branch_taken_i) begin
                            if (branch_dir_i) m_pc = (m_pc - int'(branch_off_i) + 256) % 256;
                            else              m_pc = (m_pc + int'(branch_off_i)) % 256;
                        end else if (m_pc == 255) begin
                            m_pc   = 0;
                            m_err  = 1'b1;
                            m_mode = M_FAULT;
                        end else begin
                            m_pc = m_pc + 1;
                        end
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        start_i        = 1'b0;
        start_addr_i   = 8'h00;
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        branch_dir_i   = 1'b0;
        branch_off_i   = 8'h00;
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rom_nops();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_mode == M_DONE) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic launch(input logic [7:0] addr);
        start_i      = 1'b1;
        start_addr_i = addr;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took_fwd;
        bit took_back;
        int guard;
        rom_nops();
        reset_dut();
        chk("rst_pc", rom_addr_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_valid", inst_valid_o, 0);

        // sequential fetch 0..5 with halt at 5
        rom_nops();
        rom[5] = 8'h88;
        launch(8'h00);
        for (int i = 0; i < 6; i++) begin
            chk("seq_pc", rom_addr_o, i);
            step();
        end
        chk("seq_done", done_o, 1);
        chk("seq_count", count_o, 6);
        step();
        chk("seq_done_once", done_o, 0);
        repeat (3) step();
        chk("seq_idle_count", count_o, 6);
        chk("seq_idle_pc", rom_addr_o, 5);

        // branches: 17 -> 26 forward, 49 -> 37 backward once, halt at 55
        rom_nops();
        rom[55] = 8'h88;
        launch(8'd10);
        took_fwd  = 1'b0;
        took_back = 1'b0;
        for (int i = 0; i < 120 && m_mode != M_DONE; i++) begin
            if (m_mode == M_RUN && m_pc == 17 && !took_fwd) begin
                branch_taken_i = 1'b1; branch_dir_i = 1'b0; branch_off_i = 8'd9;
                step();
                branch_taken_i = 1'b0;
                took_fwd = 1'b1;
                chk("br_fwd_pc", rom_addr_o, 26);
            end else if (m_mode == M_RUN && m_pc == 49 && !took_back) begin
                branch_taken_i = 1'b1; branch_dir_i = 1'b1; branch_off_i = 8'd12;
                step();
                branch_taken_i = 1'b0;
                took_back = 1'b1;
                chk("br_back_pc", rom_addr_o, 37);
            end else begin
                step();
            end
        end
        chk("br_done", done_o, 1);
        chk("br_count", count_o, 8 + 24 + 19);
        step();

        // stall at PC 20 with a branch request that must be ignored
        rom_nops();
        rom[30] = 8'h88;
        launch(8'd18);
        step();
        step();
        stall_i        = 1'b1;
        branch_taken_i = 1'b1;
        branch_off_i   = 8'd5;
        repeat (3) begin
            step();
            chk("stall_pc", rom_addr_o, 20);
            chk("stall_count", count_o, 2);
        end
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        step();
        chk("stall_release_pc", rom_addr_o, 21);
        run_until_done("stall_done", 40);
        step();

        // sequential wrap from 0xFF faults
        rom_nops();
        launch(8'hFE);
        step();
        step();
        chk("wrap_err", err_o, 1);
        chk("wrap_busy", busy_o, 0);
        chk("wrap_pc", rom_addr_o, 0);
        repeat (3) step();
        chk("wrap_hold_err", err_o, 1);
        rom[2] = 8'h88;
        launch(8'h00);
        chk("wrap_clear_err", err_o, 0);
        chk("wrap_restart_busy", busy_o, 1);
        run_until_done("wrap_done", 20);
        step();

        // fill opcode at PC 3
        rom_nops();
        rom[3]  = 8'hFF;
        rom[10] = 8'h88;
        launch(8'h00);
        repeat (4) step();
`ifdef FETCH_ILLEGAL_TRAP_EN
        chk("fill_err", err_o, 1);
        chk("fill_count", count_o, 3);
        chk("fill_busy", busy_o, 0);
`else
        chk("fill_pc", rom_addr_o, 4);
        chk("fill_err", err_o, 0);
        run_until_done("fill_done", 20);
`endif
        step();

        // async reset mid-program at PC 40, then restart with start held through DONE
        rom_nops();
        rom[45] = 8'h88;
        launch(8'd30);
        for (int i = 0; i < 20 && m_pc != 40; i++) step();
        chk("pre_rst_pc", rom_addr_o, 40);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_pc", rom_addr_o, 0);
        chk("async_rst_count", count_o, 0);
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_valid", inst_valid_o, 0);
        chk("async_rst_done", done_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        start_i      = 1'b1;
        start_addr_i = 8'd40;
        step();
        run_until_done("restart_first_done", 20);
        step();
        chk("restart_idle_busy", busy_o, 0);
        step();
        chk("restart_busy", busy_o, 1);
        chk("restart_pc", rom_addr_o, 40);
        start_i = 1'b0;
        run_until_done("restart_second_done", 20);
        step();

        // randomized programs, inputs and occasional resets
        reset_dut();
        guard = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_dut();
            end
            start_i        = ($urandom_range(0, 3) == 0);
            start_addr_i   = 8'($urandom);
            stall_i        = ($urandom_range(0, 4) == 0);
            branch_taken_i = ($urandom_range(0, 5) == 0);
            branch_dir_i   = 1'($urandom);
            branch_off_i   = 8'($urandom);
            if (m_mode != M_RUN && start_i) begin
                for (int a = 0; a < 256; a++) begin
                    case ($urandom_range(0, 39))
                        0, 1:    rom[a] = 8'h88;
                        2:       rom[a] = 8'hFF;
                        default: rom[a] = 8'($urandom);
                    endcase
                end
                if ($urandom_range(0, 3) == 0) start_addr_i = 8'($urandom_range(250, 255));
            end
            if (m_mode == M_DONE) guard++;
            step();
        end
        chk("rand_saw_done", guard > 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
